eth_fcs_appender: RTL
=====================

ETH_FCS_APPENDER -- requirements
Module: eth_fcs_appender

Interface
REQ-001 Parameter MIN_FRAME, default 60, minimum frame length in bytes before FCS (0 disables padding, legal range 0..127).
REQ-002 Parameter PAD_BYTE, default 8'h00, value of inserted pad bytes.
REQ-003 clk  input  1  clock, all logic on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 s_data  input  8  upstream frame byte (destination MAC first, no FCS).
REQ-006 s_valid  input  1  s_data valid.
REQ-007 s_last  input  1  s_data is last byte of frame.
REQ-008 s_ready  output  1  block accepts s_data this cycle.
REQ-009 m_data  output  8  downstream byte.
REQ-010 m_valid  output  1  m_data valid.
REQ-011 m_last  output  1  m_data is last FCS byte of frame.
REQ-012 m_ready  input  1  downstream accepts m_data this cycle.
REQ-013 busy  output  1  frame in progress (at least one byte accepted, final FCS byte not yet transferred).

Function
REQ-014 The block shall use the states DATA, PAD and FCS, resetting to DATA.
REQ-015 In DATA: m_data=s_data, m_valid=s_valid, s_ready=m_ready, m_last=0 (combinational pass-through, zero latency).
REQ-016 A transfer shall occur only on a cycle with valid and ready both high; no byte shall be dropped or duplicated while m_ready is low.
REQ-017 Each DATA or PAD transfer shall feed the transferred byte to the CRC engine with crc_en high for exactly that cycle.
REQ-018 A 7-bit byte counter shall increment per DATA/PAD transfer, saturating at 127, and clear to 0 when the frame ends.
REQ-019 On the s_last transfer: if count+1 < MIN_FRAME, go to PAD; else go to FCS.
REQ-020 In PAD: s_ready=0, m_valid=1, m_data=PAD_BYTE; on the transfer for which count+1 = MIN_FRAME, go to FCS.
REQ-021 In FCS: s_ready=0, m_valid=1, m_data = crc_out byte selected by a 2-bit index (0: [7:0], 1: [15:8], 2: [23:16], 3: [31:24]), index advances per transfer.
REQ-022 m_last shall be 1 only while index=3 in FCS; on that transfer go to DATA, clear counter and index, and pulse the CRC engine clr for one cycle.
REQ-023 crc_out shall be held stable throughout FCS (crc_en low); a registered one-cycle CRC latency is covered because FCS is entered on the edge that registers the final CRC update.
REQ-024 m_ready low in PAD/FCS shall hold m_data, index and counter unchanged.
REQ-025 Frames of length >= MIN_FRAME shall get no pad bytes; a 1-byte frame with MIN_FRAME=60 shall get 59 pad bytes.
REQ-026 busy shall be 1 from the cycle after the first DATA transfer of a frame until the cycle after the m_last transfer.

Reset
REQ-027 rst_n low shall force state DATA, counter 0, index 0, busy 0, CRC engine to initial value; outputs then follow REQ-015.
REQ-028 Reset mid-frame shall abandon the frame with no FCS emitted; the next accepted byte starts a new frame.

Structure
REQ-029 State enum, index width and FCS byte count (4) shall live in a shared package eth_fcs_appender_package.
REQ-030 The CRC shall be computed by one instance of the existing crc_32_byte sub-module (reflected, complemented, Ethernet polynomial); no CRC logic is duplicated.

Verification
REQ-031 MIN_FRAME=0, bytes "123456789" (0x31..0x39), m_ready=1 -> output is 9 data bytes then 0x26,0x39,0xF4,0xCB with m_last on 0xCB.
REQ-032 MIN_FRAME=60, 42-byte ARP frame -> 42 data bytes, 18 bytes 0x00, 4 FCS bytes; 64 m_valid transfers total.
REQ-033 MIN_FRAME=60, 60-byte and 61-byte frames -> 0 pad bytes, FCS follows last data byte immediately.
REQ-034 Random m_ready deassertion in DATA/PAD/FCS -> byte sequence identical to the m_ready=1 run; s_ready low whenever m_ready low.
REQ-035 rst_n low during PAD of frame 1 -> no FCS for frame 1; frame 2 = "123456789" with MIN_FRAME=0 yields 0x26,0x39,0xF4,0xCB.
REQ-036 Two back-to-back frames -> second FCS correct, proving clr on final FCS transfer.

Source files
------------

// File: rtl/eth_fcs_appender_pkg.sv
// eth_fcs_appender_package: shared FSM states, FCS sizing and the reflected CRC-32 byte step
package eth_fcs_appender_package;
  typedef enum logic [1:0] {
    ST_DATA = 2'd0,
    ST_PAD  = 2'd1,
    ST_FCS  = 2'd2
  } state_t;
  localparam int IDX_W = 2;
  localparam int FCS_BYTES = 4;
  localparam logic [31:0] CRC_POLY = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;
  // One byte of the reflected Ethernet CRC, LSB of the byte first.
  function automatic logic [31:0] crc_byte_step(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++)
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
    return r;
  endfunction
endpackage

// File: rtl/eth_fcs_appender_crc.sv
// crc_32_byte: registered byte-wide Ethernet CRC-32 with complemented output
module crc_32_byte
  import eth_fcs_appender_package::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        crc_en,
  input  logic        clr,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);
  logic [31:0] r_crc;
  // Running remainder; clr wins so a frame's last FCS transfer reseeds for the next frame.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_crc <= CRC_INIT;
    else if (clr) r_crc <= CRC_INIT;
    else if (crc_en) r_crc <= crc_byte_step(r_crc, data);
  assign crc_out = ~r_crc;
endmodule

// File: rtl/eth_fcs_appender.sv
// eth_fcs_appender: passes a frame through, pads it to MIN_FRAME bytes and appends the 4-byte FCS
module eth_fcs_appender
  import eth_fcs_appender_package::*;
#(
  parameter int          MIN_FRAME = 60,
  parameter logic [7:0]  PAD_BYTE  = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic [7:0] m_data,
  output logic       m_valid,
  output logic       m_last,
  input  logic       m_ready,
  output logic       busy
);
  localparam logic [7:0] MIN_LEN = 8'(MIN_FRAME);
  state_t           r_state;
  logic [6:0]       r_cnt;
  logic [IDX_W-1:0] r_idx;
  logic             r_busy;
  logic [31:0]      w_crc;
  logic [7:0]       w_fcs_byte;
  logic [7:0]       w_cnt_inc;
  logic             w_in_data;
  logic             w_xfer;
  logic             w_crc_en;
  logic             w_clr;
  logic             w_reach;
  assign w_in_data  = r_state == ST_DATA;
  assign w_fcs_byte = 8'(w_crc >> {r_idx, 3'b000});
  assign s_ready    = w_in_data & m_ready;
  assign m_valid    = w_in_data ? s_valid : 1'b1;
  assign m_data     = w_in_data ? s_data : (r_state == ST_PAD) ? PAD_BYTE : w_fcs_byte;
  assign m_last     = (r_state == ST_FCS) && (r_idx == IDX_W'(FCS_BYTES - 1));
  assign w_xfer     = m_valid & m_ready;
  assign w_crc_en   = w_xfer & (r_state != ST_FCS);
  assign w_clr      = w_xfer & m_last;
  assign w_cnt_inc  = {1'b0, r_cnt} + 8'd1;
  assign w_reach    = w_cnt_inc >= MIN_LEN;
  assign busy       = r_busy;
  // The byte being transferred on m_data is exactly what enters the CRC, pad bytes included.
  crc_32_byte u_crc (
    .clk    (clk),
    .rst_n  (rst_n),
    .crc_en (w_crc_en),
    .clr    (w_clr),
    .data   (m_data),
    .crc_out(w_crc)
  );
  // Frame sequencing: data pass-through, optional padding, then four FCS bytes LSB first.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= ST_DATA;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_busy  <= 1'b0;
    end else if (w_clr) begin
      r_state <= ST_DATA;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_busy  <= 1'b0;
    end else if (w_xfer && r_state == ST_FCS) begin
      r_idx <= r_idx + 1'b1;
    end else if (w_xfer) begin
      r_cnt  <= (r_cnt == 7'd127) ? r_cnt : r_cnt + 7'd1;
      r_busy <= 1'b1;
      if (r_state == ST_PAD || s_last) r_state <= w_reach ? ST_FCS : ST_PAD;
    end
endmodule
